// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register with valid bit, flush, delay-slot pass-through and perf counters.
// Latency: 1 cycle from upstream inputs to all outputs; every output is a flop.
// Backpressure: the shared stall vector (upstream/downstream bits) chooses advance, bubble or hold.
module pipe_stage_reg #(
    parameter int                   PAYLOAD_W   = 110,
    parameter int                   STALL_W     = 6,
    parameter int                   STAGE_IDX   = 2,
    parameter logic [PAYLOAD_W-1:0] NOP_PAYLOAD = {PAYLOAD_W{1'b0}},
    parameter int                   CNT_W       = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [STALL_W-1:0]   stall,
    input  logic                 flush,
    input  logic                 up_valid,
    input  logic [PAYLOAD_W-1:0] up_payload,
    input  logic                 up_delayslot,
    input  logic                 up_next_delayslot,
    input  logic                 clr_cnt,
    output logic                 dn_valid,
    output logic [PAYLOAD_W-1:0] dn_payload,
    output logic                 dn_delayslot,
    output logic                 next_delayslot_o,
    output logic [CNT_W-1:0]     bubble_cnt,
    output logic [CNT_W-1:0]     stall_cnt,
    output logic [CNT_W-1:0]     flush_cnt
);

    // The downstream stall bit sits one above ours, so the index must leave room for it.
    generate
        if (STAGE_IDX < 0 || STAGE_IDX > STALL_W - 2) begin : g_bad_stage_idx
            $error("pipe_stage_reg: STAGE_IDX out of range 0..STALL_W-2");
        end
    endgenerate

    // Per-cycle action decoded from flush and the two stall bits (reset handled separately).
    typedef enum logic [1:0] {
        ACT_ADVANCE = 2'd0,
        ACT_BUBBLE  = 2'd1,
        ACT_HOLD    = 2'd2,
        ACT_FLUSH   = 2'd3
    } act_e;

    logic us;
    logic ds;
    act_e act;

    assign us = stall[STAGE_IDX];
    assign ds = stall[STAGE_IDX+1];

    // Saturating increment: the counter sticks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    // Priority decode: flush beats every stall combination; us=0 always advances,
    // including the (illegal) us=0/ds=1 case.
    always_comb begin
        act = ACT_ADVANCE;
        if (flush) begin
            act = ACT_FLUSH;
        end else if (!us) begin
            act = ACT_ADVANCE;
        end else if (!ds) begin
            act = ACT_BUBBLE;
        end else begin
            act = ACT_HOLD;
        end
    end

    // Datapath register; dn_valid doubles as the occupancy bit (0 empty, 1 full).
    always_ff @(posedge clk) begin
        if (rst) begin
            dn_valid         <= 1'b0;
            dn_payload       <= NOP_PAYLOAD;
            dn_delayslot     <= 1'b0;
            next_delayslot_o <= 1'b0;
        end else begin
            unique case (act)
                ACT_FLUSH: begin
                    dn_valid         <= 1'b0;
                    dn_payload       <= NOP_PAYLOAD;
                    dn_delayslot     <= 1'b0;
                    next_delayslot_o <= 1'b0;
                end
                ACT_BUBBLE: begin
                    // The decoder feedback is kept across a bubble so the
                    // delay-slot knowledge is not lost while upstream is stopped.
                    dn_valid     <= 1'b0;
                    dn_payload   <= NOP_PAYLOAD;
                    dn_delayslot <= 1'b0;
                end
                ACT_ADVANCE: begin
                    dn_valid         <= up_valid;
                    dn_payload       <= up_payload;
                    dn_delayslot     <= up_delayslot;
                    next_delayslot_o <= up_next_delayslot;
                end
                default: begin
                    // ACT_HOLD: every output keeps its value.
                end
            endcase
        end
    end

    // Performance counters; clear sits below reset and above any increment.
    always_ff @(posedge clk) begin
        if (rst || clr_cnt) begin
            bubble_cnt <= '0;
            stall_cnt  <= '0;
            flush_cnt  <= '0;
        end else begin
            unique case (act)
                ACT_FLUSH:  flush_cnt  <= sat_inc(flush_cnt);
                ACT_BUBBLE: bubble_cnt <= sat_inc(bubble_cnt);
                ACT_HOLD:   stall_cnt  <= sat_inc(stall_cnt);
                default: begin
                end
            endcase
        end
    end

    // A monotonic stall vector never stops downstream while upstream runs.
    a_stall_order: assert property (@(posedge clk) disable iff (rst) !(!us && ds))
        else $error("pipe_stage_reg: downstream stalled while upstream advances");

    // The whole stall vector must be driven to known values outside reset.
    a_stall_known: assert property (@(posedge clk) disable iff (rst) !$isunknown(stall))
        else $error("pipe_stage_reg: stall vector has unknown bits");

endmodule
